parity_check: RTL and testbench
===============================

Name: parity_check

Overview:
- Receive-side counterpart of the serial parity generator: takes a data word plus its received parity bit and checks them.
- Shifts the word out LSB-first and toggles a 1-bit accumulator on every '1'.
- Stops early once the remaining bits are all zero.
- Reports a parity error flag with a one-cycle done pulse. Sits after the link/receive register, ahead of error handling.

Parameters:
WIDTH, 8, data word width in bits (WIDTH >= 1)
ODD, 0, parity convention: 0 = even (ones in data+parity must be even), 1 = odd

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
init  input  1  start request, sampled only in IDLE
data_in  input  WIDTH  received data word, sampled on start edge only
par_in  input  1  received parity bit, sampled on start edge only
busy  output  1  high while a check is in progress
done  output  1  one-cycle pulse: check finished, err valid
err  output  1  parity mismatch result, held until next start

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, acc=0, busy=0, done=0, err=0. Reset mid-check aborts the check; no done is produced.
- States: IDLE, SHIFT.
- IDLE, edge E0 with init=1:
  - shift reg <= data_in; acc <= par_in.
  - err <= 0; busy <= 1; go to SHIFT.
  - init=0: stay in IDLE, all outputs hold.
- SHIFT, each edge:
  - If shift reg != 0: acc <= acc ^ shreg[0]; shreg <= shreg >> 1 (logical, zero fill).
  - If shift reg == 0: err <= acc ^ ODD; done <= 1; busy <= 0; go to IDLE.
- Latency: let k = (index of highest '1' in data_in) + 1, with k = 0 for all-zero data.
  - Shifts occur at E1..Ek.
  - done/err update at E(k+1); done clears at E(k+2).
  - Worst case WIDTH+1 cycles (MSB set); best case 1 cycle (data zero).
- done is a registered pulse, exactly one cycle wide.
- err is registered and stable from the done cycle until the next accepted start. It is cleared to 0 at that start edge.
- Input changes after E0 are ignored. init while busy=1 is ignored; it is not queued.
- init held high continuously: a new check starts at the first IDLE edge, i.e. the same edge that clears done. Back-to-back checks have no idle gap beyond that single IDLE cycle.
- WIDTH=1: k is 0 or 1; same rules apply.
- Arithmetic: acc is 1 bit (mod-2 ones count). Final acc = XOR(data_in) ^ par_in. err = 1 iff this differs from ODD.

Test Plan:
- ODD=0, data_in=8'hA5, par_in=0, init pulse at E0 -> busy 1 over E0..E9; done=1 at E9 only; err=0 (four ones, even).
- ODD=0, data_in=8'h03, par_in=1 -> done at E3; err=1 (three ones total). err stays 1 until the next start, then clears at that start edge.
- ODD=0, data_in=8'h00, par_in=0 -> done at E1, err=0. Repeat with par_in=1 -> done at E1, err=1.
- ODD=1, data_in=8'h80, par_in=0 -> done at E9, err=0. With par_in=1 -> err=1.
- Start check on 8'hFF, pulse init again at E3 (busy) -> ignored; single done at E9, err per 8'hFF/par_in only. Hold init=1 permanently -> checks repeat, done pulses separated by k+2 cycles.
- Start on 8'hF0, assert rst=0 asynchronously at E2+half-cycle -> busy, done, err read 0 immediately. No done follows after rst=1. Next init runs a clean check.

Source files
------------

// File: rtl/parity_check.sv
// rtl/parity_check.sv - serial LSB-first parity checker with early stop on zero remainder
// Returns a registered err flag and a one-cycle done pulse per accepted check.
module parity_check #(
   parameter int WIDTH = 8,
   parameter bit ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [WIDTH-1:0] data_in,
   input  logic             par_in,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         acc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (init) state_d = SHIFT;
         SHIFT: if (shreg_q == '0) state_d = IDLE;
      endcase
   end

   // The accumulator is seeded with the received parity bit, so once the word is
   // drained it holds XOR(data)^par and only needs comparing against ODD.
   always_comb begin
      shreg_d = shreg_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (init) begin
               shreg_d = data_in;
               acc_d   = par_in;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            if (shreg_q != '0) begin
               acc_d   = acc_q ^ shreg_q[0];
               shreg_d = shreg_q >> 1;
            end else begin
               err_d  = acc_q ^ ODD;
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_parity_check.sv
// tb/tb_parity_check.sv - scoreboard bench for parity_check, even and odd instances side by side
// Expected done cycle and err are queued at stimulus time and popped by the monitor.
module tb_parity_check;

   typedef struct {
      int   cyc;
      logic err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       init = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       par_in = 1'b0;
   logic       busy0, done0, err0;
   logic       busy1, done1, err1;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   exp_t q0[$];
   exp_t q1[$];

   parity_check #(.WIDTH(8), .ODD(1'b0)) u_even (
      .clk(clk), .rst(rst), .init(init), .data_in(data_in), .par_in(par_in),
      .busy(busy0), .done(done0), .err(err0)
   );

   parity_check #(.WIDTH(8), .ODD(1'b1)) u_odd (
      .clk(clk), .rst(rst), .init(init), .data_in(data_in), .par_in(par_in),
      .busy(busy1), .done(done1), .err(err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (done0) begin
            if (q0.size() == 0) chk("even_spurious_done", 1, 0);
            else begin
               exp_t e;
               e = q0.pop_front();
               chk("even_done_cycle", cyc, e.cyc);
               chk("even_err", int'(err0), int'(e.err));
               chk("even_busy_at_done", int'(busy0), 0);
            end
         end
         if (done1) begin
            if (q1.size() == 0) chk("odd_spurious_done", 1, 0);
            else begin
               exp_t e;
               e = q1.pop_front();
               chk("odd_done_cycle", cyc, e.cyc);
               chk("odd_err", int'(err1), int'(e.err));
               chk("odd_busy_at_done", int'(busy1), 0);
            end
         end
      end
   end

   // k = index of highest set bit + 1 (0 for zero data); e0 = expected err with ODD=0
   task automatic start_chk(input logic [7:0] d, input logic p, input int k, input logic e0);
      @(negedge clk);
      data_in = d;
      par_in  = p;
      init    = 1'b1;
      q0.push_back('{cyc: cyc + k + 2, err: e0});
      q1.push_back('{cyc: cyc + k + 2, err: ~e0});
      @(negedge clk);
      init    = 1'b0;
      data_in = ~d;
      par_in  = ~p;
      chk("busy_e0_even", int'(busy0), 1);
      chk("busy_e0_odd", int'(busy1), 1);
      chk("err_clear_even", int'(err0), 0);
      chk("err_clear_odd", int'(err1), 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         chk("done_timeout", q0.size() + q1.size(), 0);
         q0.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy0 | busy1), 0);
      chk("rst_done", int'(done0 | done1), 0);
      chk("rst_err", int'(err0 | err1), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      start_chk(8'hA5, 1'b0, 8, 1'b0);
      wait_idle();

      start_chk(8'h03, 1'b1, 2, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("err_hold_even", int'(err0), 1);
      chk("err_hold_odd", int'(err1), 0);

      start_chk(8'h00, 1'b0, 0, 1'b0);
      wait_idle();
      start_chk(8'h00, 1'b1, 0, 1'b1);
      wait_idle();

      start_chk(8'h80, 1'b0, 8, 1'b1);
      wait_idle();
      start_chk(8'h80, 1'b1, 8, 1'b0);
      wait_idle();

      // init pulse at E3 while busy must be dropped, not queued
      start_chk(8'hFF, 1'b0, 8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      data_in = 8'h01;
      par_in  = 1'b1;
      init    = 1'b1;
      @(negedge clk);
      init = 1'b0;
      wait_idle();
      repeat (12) @(negedge clk);

      // init held high: 8'h05 (k=3) restarts every k+2 = 5 cycles
      @(negedge clk);
      n0      = cyc;
      data_in = 8'h05;
      par_in  = 1'b1;
      init    = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         q0.push_back('{cyc: n0 + 5 * i, err: 1'b1});
         q1.push_back('{cyc: n0 + 5 * i, err: 1'b0});
      end
      for (int i = 0; i < 40 && cyc < n0 + 15; i++) @(negedge clk);
      init = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);

      // asynchronous abort half a cycle after E2
      start_chk(8'hF0, 1'b0, 8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", int'(busy0 | busy1), 0);
      chk("abort_done", int'(done0 | done1), 0);
      chk("abort_err", int'(err0 | err1), 0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);

      start_chk(8'hF0, 1'b1, 8, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
